// File: rtl/mips_div_clz.sv
// mips_div_clz
//   Iterative radix-2 restoring divider for MIPS DIV/DIVU. A count-leading-zeros
//   of |dividend| normalises the dividend so only DATA_WIDTH-lz iterations run;
//   the skipped iterations could only ever produce zero quotient bits.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 new request, accepted only when the unit is idle
//   signed_i                1 = DIV (two's complement), 0 = DIVU
//   annul_i                 flush: abort the in-flight op, no done_o
//   dividend_i, divisor_i   operands, captured with start_i
//   busy_o                  op in flight (PREP/ITER/FIX)
//   done_o                  one-cycle pulse, quot_o/rem_o/dbz_o valid
//   dbz_o                   divide-by-zero flag for this result
//   quot_o, rem_o           quotient (LO) / remainder (HI), held until next done_o
//   state_o                 FSM state for observation (0 IDLE,1 PREP,2 ITER,3 FIX)
//
// Handshake: start_i is a request that is taken only in a cycle where busy_o=0
// and annul_i=0; there is no queuing. done_o pulses exactly once per completed
// (not annulled) operation, in the cycle after FIX, with busy_o already low.
module mips_div_clz #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_LOG2 = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic                  annul_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  dbz_o,
  output logic [DATA_WIDTH-1:0] quot_o,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic [1:0]            state_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = DATA_WIDTH_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  a_q, b_q;       // operands as captured
  logic          sgn_q;
  logic [W-1:0]  a_sh;           // normalised |a|, consumed MSB first
  logic [W-1:0]  mag_b_q;
  logic [W-1:0]  part_rem;
  logic [W-1:0]  quot_w;
  logic [CW-1:0] cnt;
  logic          dbz_w;

  logic [W-1:0]  mag_a, mag_b;
  logic [CW-1:0] lz;
  logic [W:0]    trial;
  logic          ge;
  logic [W-1:0]  diff;
  logic          neg_q, neg_r;

  assign mag_a = (sgn_q && a_q[W-1]) ? -a_q : a_q;
  assign mag_b = (sgn_q && b_q[W-1]) ? -b_q : b_q;

  // Leading-zero count of |a|; ascending scan so the highest set bit wins.
  always_comb begin
    lz = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (mag_a[i]) lz = CW'(W - 1 - i);
    end
  end

  // Full-width compare on W+1 bits; the subtraction only needs W bits because
  // the result is always below |b|.
  assign trial = {part_rem, a_sh[W-1]};
  assign ge    = (trial >= {1'b0, mag_b_q});
  assign diff  = trial[W-1:0] - mag_b_q;

  assign neg_q = sgn_q & (a_q[W-1] ^ b_q[W-1]);
  assign neg_r = sgn_q & a_q[W-1];

  assign busy_o  = (state != IDLE);
  assign state_o = state;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start_i && !annul_i) state_nx = PREP;
      PREP: if (b_q == '0 || lz == CW'(W)) state_nx = FIX;
            else                           state_nx = ITER;
      ITER: if (cnt == CW'(1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (annul_i && state != IDLE) state_nx = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      a_sh     <= '0;
      mag_b_q  <= '0;
      part_rem <= '0;
      quot_w   <= '0;
      cnt      <= '0;
      dbz_w    <= 1'b0;
      done_o   <= 1'b0;
      dbz_o    <= 1'b0;
      quot_o   <= '0;
      rem_o    <= '0;
    end else begin
      done_o <= (state == FIX) && !annul_i;
      unique case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            a_q   <= dividend_i;
            b_q   <= divisor_i;
            sgn_q <= signed_i;
          end
        end
        PREP: begin
          mag_b_q <= mag_b;
          dbz_w   <= 1'b0;
          if (b_q == '0) begin
            // Divide by zero: raw dividend goes to HI, no sign fix-up.
            dbz_w    <= 1'b1;
            quot_w   <= '1;
            part_rem <= a_q;
          end else if (lz == CW'(W)) begin
            quot_w   <= '0;
            part_rem <= '0;
          end else begin
            a_sh     <= mag_a << lz;
            part_rem <= '0;
            quot_w   <= '0;
            cnt      <= CW'(W) - lz;
          end
        end
        ITER: begin
          part_rem <= ge ? diff : trial[W-1:0];
          quot_w   <= {quot_w[W-2:0], ge};
          a_sh     <= a_sh << 1;
          cnt      <= cnt - CW'(1);
        end
        FIX: begin
          if (!annul_i) begin
            dbz_o  <= dbz_w;
            quot_o <= (!dbz_w && neg_q) ? -quot_w   : quot_w;
            rem_o  <= (!dbz_w && neg_r) ? -part_rem : part_rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_clz.sv
// tb_mips_div_clz
//   Self-checking bench for mips_div_clz: a table of hand-computed vectors,
//   randomised operands against a behavioural model, and hand-written sequences
//   for ignored start, annul, mid-op reset and back-to-back issue.
module tb_mips_div_clz;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i, start_i, signed_i, annul_i;
  logic [W-1:0] dividend_i, divisor_i;
  logic         busy_o, done_o, dbz_o;
  logic [W-1:0] quot_o, rem_o;
  logic [1:0]   state_o;

  mips_div_clz #(.DATA_WIDTH(32), .DATA_WIDTH_LOG2(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .signed_i(signed_i),
    .annul_i(annul_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
    .busy_o(busy_o), .done_o(done_o), .dbz_o(dbz_o), .quot_o(quot_o),
    .rem_o(rem_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  logic         exp_dbz[$];
  int           exp_lat[$];
  logic [W-1:0] last_q = '0, last_r = '0;
  logic         last_dbz = 1'b0;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int lat_model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] mag;
    if (b == '0) return 3;
    mag = (s && a[W-1]) ? -a : a;
    for (int i = W - 1; i >= 0; i--) if (mag[i]) return i + 4;
    return 3;
  endfunction

  task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r, input logic d, input int lat);
    exp_q.push_back(q);
    exp_r.push_back(r);
    exp_dbz.push_back(d);
    exp_lat.push_back(lat);
  endtask

  // driver: called just after a falling edge; start is sampled at the next rise
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    signed_i   = s;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc     = 1;
  endtask

  task automatic wait_done(input string tag);
    logic [W-1:0] q, r;
    logic         d;
    int           lat;
    while (!done_o && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
    end
    q = exp_q.pop_front();
    r = exp_r.pop_front();
    d = exp_dbz.pop_front();
    lat = exp_lat.pop_front();
    check({tag, "_done_seen"}, 64'(done_o), 64'(1));
    if (done_o) begin
      check({tag, "_quot"}, 64'(quot_o), 64'(q));
      check({tag, "_rem"},  64'(rem_o),  64'(r));
      check({tag, "_dbz"},  64'(dbz_o),  64'(d));
      check({tag, "_lat"},  64'(cyc),    64'(lat));
      check({tag, "_busy_at_done"}, 64'(busy_o), 64'(0));
      last_q = q; last_r = r; last_dbz = d;
    end
  endtask

  task automatic watch_no_done(input string tag, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
    end
    check({tag, "_no_done"}, 64'(seen), 64'(0));
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 10};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 6};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 6};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 35};
    vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 35};
    vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 3};
    vecs[6]  = '{1'b0, 32'd0,          32'd9,          32'd0,          32'd0,          1'b0, 3};
    vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1, 3};
    vecs[8]  = '{1'b0, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          1'b0, 35};
    vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 10};
    vecs[10] = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0, 35};
    vecs[11] = '{1'b0, 32'd1,          32'd1,          32'd1,          32'd0,          1'b0, 4};

    rst_i = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_busy",  64'(busy_o),  64'(0));
    check("rst_done",  64'(done_o),  64'(0));
    check("rst_dbz",   64'(dbz_o),   64'(0));
    check("rst_quot",  64'(quot_o),  64'(0));
    check("rst_rem",   64'(rem_o),   64'(0));
    check("rst_state", 64'(state_o), 64'(0));
    rst_i = 1'b0;
    @(negedge clk_i);

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      push_exp(vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat);
      launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_busy", i), 64'(busy_o), 64'(1));
      wait_done($sformatf("vec%0d", i));
    end

    // randomised operands against the model
    for (int i = 0; i < 20; i++) begin
      logic         s;
      logic [W-1:0] a, b, q, r;
      s = 1'($urandom_range(0, 1));
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if (b == '0) b = 32'd3;
      if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd5;
      if (s) begin
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        q = W'(sa / sb);
        r = W'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
      push_exp(q, r, 1'b0, lat_model(s, a, b));
      launch(s, a, b);
      wait_done($sformatf("rnd%0d", i));
    end

    // ignored start while busy, then annul
    @(negedge clk_i);
    launch(1'b0, 32'd100, 32'd7);           // now in cycle 1
    repeat (3) @(negedge clk_i);            // cycle 4
    signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd5; start_i = 1'b1;
    @(negedge clk_i);                       // cycle 5
    start_i = 1'b0;
    check("ignored_start_busy", 64'(busy_o), 64'(1));
    annul_i = 1'b1;
    @(negedge clk_i);                       // cycle 6
    annul_i = 1'b0;
    check("annul_busy", 64'(busy_o), 64'(0));
    check("annul_done", 64'(done_o), 64'(0));
    check("annul_quot", 64'(quot_o), 64'(last_q));
    check("annul_rem",  64'(rem_o),  64'(last_r));
    check("annul_dbz",  64'(dbz_o),  64'(last_dbz));
    watch_no_done("annul", 40);
    push_exp(32'd3, 32'd0, 1'b0, 7);
    launch(1'b0, 32'd9, 32'd3);
    wait_done("after_annul");

    // reset in the middle of a 32-iteration op
    @(negedge clk_i);
    launch(1'b0, 32'hFFFFFFFF, 32'd1);      // cycle 1
    repeat (3) @(negedge clk_i);            // cycle 4
    rst_i = 1'b1;
    @(negedge clk_i);                       // cycle 5
    rst_i = 1'b0;
    check("midrst_busy",  64'(busy_o),  64'(0));
    check("midrst_quot",  64'(quot_o),  64'(0));
    check("midrst_rem",   64'(rem_o),   64'(0));
    check("midrst_dbz",   64'(dbz_o),   64'(0));
    check("midrst_state", 64'(state_o), 64'(0));
    watch_no_done("midrst", 40);

    // back-to-back: start in the done_o cycle is accepted
    push_exp(32'd14, 32'd2, 1'b0, 10);
    launch(1'b0, 32'd100, 32'd7);
    wait_done("b2b_first");
    push_exp(32'd3, 32'd0, 1'b0, 7);
    launch(1'b0, 32'd9, 32'd3);
    check("b2b_accept_busy", 64'(busy_o), 64'(1));
    wait_done("b2b_second");

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
